// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time/alarm edit controller.
//  - mode encodings, digit limits and cursor indices
//  - digits_t: BCD time digits (alarm reuses it; its seconds stay 0)
//  - key_press_t: one-clk debounced press pulses
//  - inc_digit(): wrap-around increment of one digit, including the
//    24-hour tens/units interlock
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE      = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  localparam logic [3:0] GE_MAX           = 4'd9;
  localparam logic [2:0] SEC_SHI_MAX      = 3'd5;  // seconds and minutes tens
  localparam logic [1:0] HOUR_SHI_MAX     = 2'd2;
  localparam logic [3:0] HOUR_GE_MAX_AT_2 = 4'd3;

  // Time cursor indices (also the digit index used by inc_digit)
  localparam logic [2:0] CUR_SEC_GE   = 3'd0;
  localparam logic [2:0] CUR_SEC_SHI  = 3'd1;
  localparam logic [2:0] CUR_MIN_GE   = 3'd2;
  localparam logic [2:0] CUR_MIN_SHI  = 3'd3;
  localparam logic [2:0] CUR_HOUR_GE  = 3'd4;
  localparam logic [2:0] CUR_HOUR_SHI = 3'd5;

  // Alarm cursor indices; alarm digit i is time digit i + CUR_MIN_GE
  localparam logic [2:0] CUR_A_MIN_GE   = 3'd0;
  localparam logic [2:0] CUR_A_MIN_SHI  = 3'd1;
  localparam logic [2:0] CUR_A_HOUR_GE  = 3'd2;
  localparam logic [2:0] CUR_A_HOUR_SHI = 3'd3;

  typedef struct packed {
    logic [1:0] hour_shi;
    logic [3:0] hour_ge;
    logic [2:0] min_shi;
    logic [3:0] min_ge;
    logic [2:0] sec_shi;
    logic [3:0] sec_ge;
  } digits_t;

  typedef struct packed {
    logic mode;
    logic shift;
    logic inc;
    logic alarm;
  } key_press_t;

  function automatic logic [3:0] inc_ge(logic [3:0] v);
    return (v >= GE_MAX) ? 4'd0 : v + 4'd1;
  endfunction

  function automatic logic [2:0] inc_shi(logic [2:0] v);
    return (v >= SEC_SHI_MAX) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic digits_t inc_digit(digits_t d, logic [2:0] idx);
    digits_t r;
    r = d;
    case (idx)
      CUR_SEC_GE:  r.sec_ge  = inc_ge(d.sec_ge);
      CUR_SEC_SHI: r.sec_shi = inc_shi(d.sec_shi);
      CUR_MIN_GE:  r.min_ge  = inc_ge(d.min_ge);
      CUR_MIN_SHI: r.min_shi = inc_shi(d.min_shi);
      CUR_HOUR_GE: begin
        if (d.hour_shi == HOUR_SHI_MAX)
          r.hour_ge = (d.hour_ge >= HOUR_GE_MAX_AT_2) ? 4'd0 : d.hour_ge + 4'd1;
        else
          r.hour_ge = inc_ge(d.hour_ge);
      end
      CUR_HOUR_SHI: begin
        r.hour_shi = (d.hour_shi >= HOUR_SHI_MAX) ? 2'd0 : d.hour_shi + 2'd1;
        // entering the 20s must not leave an illegal 24..29
        if (r.hour_shi == HOUR_SHI_MAX && d.hour_ge > HOUR_GE_MAX_AT_2)
          r.hour_ge = HOUR_GE_MAX_AT_2;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_key_debounce.sv
// key_debounce: synchronise and debounce one active-low push key.
//  clk, rst  : clock, async active-high reset (key reads as released)
//  key_n     : raw asynchronous key, active-low
//  press     : registered one-clk pulse when the debounced level falls
// The stable level flips only after the synchronised level has differed
// from it for DEB_CYCLES consecutive clocks; any agreement restarts the count.
module key_debounce #(
  parameter int DEB_CYCLES = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1, sync2, stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= ~sync2;  // only the falling (pressed) edge pulses
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: key-driven editor for the clock time and alarm.
//  clk, rst                  : clock, async active-high reset
//  key_mode_n/shift/inc/alarm: raw active-low keys
//  set_*                     : time digits being edited (BCD)
//  set_time_finish           : one-clk load strobe on leaving SET_TIME
//  clock_* / clock_en        : alarm time digits and enable
//  edit_mode / cursor        : current mode and edited digit for blinking
// Press priority in a cycle: mode > shift > inc; alarm only acts in IDLE.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_shift_n,
  input  logic       key_inc_n,
  input  logic       key_alarm_n,
  output logic [3:0] set_sec_ge,
  output logic [2:0] set_sec_shi,
  output logic [3:0] set_min_ge,
  output logic [2:0] set_min_shi,
  output logic [3:0] set_hour_ge,
  output logic [1:0] set_hour_shi,
  output logic       set_time_finish,
  output logic [3:0] clock_min_ge,
  output logic [2:0] clock_min_shi,
  output logic [3:0] clock_hour_ge,
  output logic [1:0] clock_hour_shi,
  output logic       clock_en,
  output logic [1:0] edit_mode,
  output logic [2:0] cursor
);

  logic [3:0] keys_n, press_vec;
  key_press_t press;

  assign keys_n = {key_mode_n, key_shift_n, key_inc_n, key_alarm_n};
  assign press  = key_press_t'(press_vec);

  for (genvar i = 0; i < 4; i++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .key_n (keys_n[i]),
      .press (press_vec[i])
    );
  end

  // ---------------- mode FSM ----------------
  mode_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MODE_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (press.mode) begin
      case (state_q)
        MODE_IDLE:      state_d = MODE_SET_TIME;
        MODE_SET_TIME:  state_d = MODE_SET_ALARM;
        MODE_SET_ALARM: state_d = MODE_IDLE;
        default:        state_d = MODE_IDLE;
      endcase
    end
  end

  always_comb begin
    edit_mode = state_q;
  end

  // ---------------- digit registers ----------------
  digits_t    set_q, alarm_q;
  logic [2:0] cursor_q, cursor_last;
  logic       clock_en_q, finish_q;

  assign cursor_last = (state_q == MODE_SET_TIME) ? CUR_HOUR_SHI : CUR_A_HOUR_SHI;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q      <= '0;
      alarm_q    <= '0;
      cursor_q   <= '0;
      clock_en_q <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      if (press.mode) begin
        cursor_q <= '0;
        finish_q <= (state_q == MODE_SET_TIME);
      end else if (press.shift && state_q != MODE_IDLE) begin
        cursor_q <= (cursor_q >= cursor_last) ? 3'd0 : cursor_q + 3'd1;
      end else if (press.inc && state_q == MODE_SET_TIME) begin
        set_q <= inc_digit(set_q, cursor_q);
      end else if (press.inc && state_q == MODE_SET_ALARM) begin
        // alarm cursor 0..3 maps onto the minute/hour digits
        alarm_q <= inc_digit(alarm_q, cursor_q + CUR_MIN_GE);
      end else if (press.alarm && state_q == MODE_IDLE) begin
        clock_en_q <= ~clock_en_q;
      end
    end
  end

  // alarm seconds are never edited and never leave the block
  logic [6:0] unused_alarm_sec;
  assign unused_alarm_sec = {alarm_q.sec_shi, alarm_q.sec_ge};

  assign set_sec_ge      = set_q.sec_ge;
  assign set_sec_shi     = set_q.sec_shi;
  assign set_min_ge      = set_q.min_ge;
  assign set_min_shi     = set_q.min_shi;
  assign set_hour_ge     = set_q.hour_ge;
  assign set_hour_shi    = set_q.hour_shi;
  assign set_time_finish = finish_q;
  assign clock_min_ge    = alarm_q.min_ge;
  assign clock_min_shi   = alarm_q.min_shi;
  assign clock_hour_ge   = alarm_q.hour_ge;
  assign clock_hour_shi  = alarm_q.hour_shi;
  assign clock_en        = clock_en_q;
  assign cursor          = cursor_q;

endmodule
